dp_1024x32_reader: RTL and testbench
====================================

# dp_1024x32_reader

Burst read engine for the 1024x32 dual-port EBR memory. It owns the memory's read port and takes a burst request (start address, length) over a valid/ready handshake. It streams the words out on a valid/ready interface with back-pressure and checks the per-byte parity bits (EDO) on every word. It sits between the dp_1024x32 EBR read port and downstream consumers, complementing the write-side logic that fills the memory.

## Interface
- ADDR_W, 10, memory address width (1024 words)
- DATA_W, 32, data word width
- ED_W, 4, parity bits (DATA_W/8, one per byte)
- RdClock  in  1  single clock; also drives the EBR read port
- RdResetN  in  1  reset, asynchronous, active-low
- ReqValid  in  1  burst request valid
- ReqReady  out  1  request accepted when ReqValid & ReqReady at RdClock rising edge
- ReqAddr  in  ADDR_W  first word address
- ReqLen  in  ADDR_W  word count; 0 encodes 1024
- RdEn  out  1  EBR read enable
- RdAddress  out  ADDR_W  EBR read address
- Q  in  DATA_W  EBR read data, registered output, valid one cycle after RdEn sampled
- EDO  in  ED_W  EBR parity bits accompanying Q
- OutValid  out  1  stream word valid
- OutReady  in  1  consumer ready
- OutData  out  DATA_W  stream word
- OutLast  out  1  final word of burst
- OutErr  out  1  parity mismatch on this word
- Busy  out  1  burst in progress
- Done  out  1  one-cycle pulse after the last word handshake
- ErrCount  out  8  saturating count of words with OutErr, cleared on request accept

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - ReqReady=1, Busy=0.
  - On accept: latch ReqAddr into the address counter and the length (0→1024) into the remaining counter, clear ErrCount, go to ISSUE.
- ISSUE:
  - Asserts RdEn with RdAddress = address counter when credit is available.
  - Credit rule: (fifo_count + inflight − pop) < 2, where pop = OutValid & OutReady in the same cycle.
  - Each issue increments the address modulo 1024 (1023→0) and decrements remaining.
  - After the last issue, go to DRAIN.
- DRAIN: no RdEn. When the word tagged last is handshaked, pulse Done and go to IDLE.
- Output buffer:
  - 2-entry FIFO.
  - The word is written on the cycle Q is valid (inflight flag), stored as {Q, last tag, parity error}.
  - Credit accounting guarantees the FIFO never overflows; Q is never dropped.
- Parity:
  - Expected even parity per byte: OutErr = OR over i of (EDO[i] XOR ^Q[8i+7:8i]).
  - ErrCount increments on each handshaked word with OutErr=1 and saturates at 255.
- OutData, OutLast and OutErr are stable while OutValid=1 and OutReady=0.
- ReqReady=0 in ISSUE and DRAIN; requests there are held off, not queued.
- Reset (any time, including mid-burst):
  - State IDLE, FIFO and inflight flag cleared, counters cleared.
  - Words from the aborted burst are never presented.

## Timing
- Reset values:
  - ReqReady=1.
  - RdEn=0, RdAddress=0.
  - OutValid=0, OutData=0, OutLast=0, OutErr=0.
  - Busy=0, Done=0, ErrCount=0.
- Latency, with request accepted at edge T:
  - RdEn=1 with the first address during cycle T+1.
  - Q is valid in cycle T+2.
  - OutValid=1 from cycle T+3.
- Throughput: with OutReady held 1, one word per cycle. A burst of N words shows OutValid in cycles T+3..T+N+2, OutLast in cycle T+N+2, and Done in cycle T+N+3. ReqReady returns to 1 in cycle T+N+3.
- Back-pressure: RdEn deasserts within one cycle of OutReady=0. At most 2 words are buffered. Issue resumes the cycle after credit frees.
- Busy = (state ≠ IDLE).

## Test plan
- Memory[5]=0x12345678 with correct parity; request Addr=5, Len=1, OutReady=1 → RdEn in T+1 with RdAddress=5; OutData=0x12345678 with OutLast=1, OutErr=0 in T+3; Done in T+4.
- Addr=1022, Len=4, OutReady=1 → RdAddress sequence 1022, 1023, 0, 1; four consecutive output words; OutLast only on the 4th word.
- Len=8 with OutReady toggling 1,0,0,1,…: every word appears exactly once, in order; OutData is held during stalls; the FIFO never exceeds 2 entries; RdEn=0 while credit is exhausted.
- Word 2 of a 3-word burst has EDO[1] flipped → OutErr=1 only on that word; ErrCount=1 after the burst. A new request accepted afterwards resets ErrCount to 0.
- ReqLen=0 from Addr=0 → 1024 words, addresses 0..1023; OutLast on the word from address 1023; Done one cycle after that handshake.
- RdResetN low during cycle 4 of an 8-word burst → all outputs return to reset values asynchronously. After release, ReqReady=1 and no stale OutValid appears. A new 2-word request completes normally.

Source files
------------

// File: rtl/dp_1024x32_reader.sv
// Burst read engine for the 1024x32 dual-port EBR: issues read addresses for a
// requested burst, buffers returned words in a 2-entry FIFO and streams them out with parity status.
module dp_1024x32_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int ED_W   = 4
) (
    input  logic              RdClock,
    input  logic              RdResetN,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [ADDR_W-1:0] ReqLen,
    output logic              RdEn,
    output logic [ADDR_W-1:0] RdAddress,
    input  logic [DATA_W-1:0] Q,
    input  logic [ED_W-1:0]   EDO,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutData,
    output logic              OutLast,
    output logic              OutErr,
    output logic              Busy,
    output logic              Done,
    output logic [7:0]        ErrCount
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic                inflight_q, inflight_d;
    logic                inflight_last_q, inflight_last_d;
    logic [DATA_W-1:0]   fifo_data_q [2];
    logic [DATA_W-1:0]   fifo_data_d [2];
    logic [1:0]          fifo_last_q, fifo_last_d;
    logic [1:0]          fifo_err_q, fifo_err_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          count_q, count_d;
    logic                done_q, done_d;
    logic [7:0]          err_cnt_q, err_cnt_d;

    logic [ED_W-1:0]     byte_par;
    logic                q_err;
    logic                push;
    logic                pop;
    logic                head_last;
    logic                head_err;
    logic [2:0]          occupancy;
    logic                issue;

    // Even parity per byte: each EDO bit must equal the XOR of its byte.
    generate
        for (genvar gi = 0; gi < ED_W; gi++) begin : g_par
            assign byte_par[gi] = ^Q[8*gi +: 8];
        end
    endgenerate
    assign q_err = |(EDO ^ byte_par);

    assign push      = inflight_q;
    assign pop       = (count_q != 2'd0) && OutReady;
    assign head_last = fifo_last_q[rd_ptr_q];
    assign head_err  = fifo_err_q[rd_ptr_q];

    // Words buffered or on their way back from the EBR after this cycle's pop.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = (state_q == ISSUE) && (occupancy < 3'd2);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            always_comb begin
                fifo_data_d[gi] = fifo_data_q[gi];
                fifo_last_d[gi] = fifo_last_q[gi];
                fifo_err_d[gi]  = fifo_err_q[gi];
                if (push && (wr_ptr_q == 1'(gi))) begin
                    fifo_data_d[gi] = Q;
                    fifo_last_d[gi] = inflight_last_q;
                    fifo_err_d[gi]  = q_err;
                end
            end
        end
    endgenerate

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        err_cnt_d       = err_cnt_q;
        inflight_d      = issue;
        inflight_last_d = issue && (rem_q == (ADDR_W+1)'(1));
        count_d         = count_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d        = wr_ptr_q ^ push;
        rd_ptr_d        = rd_ptr_q ^ pop;
        done_d          = 1'b0;

        if (pop && head_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (ReqValid) begin
                    addr_d    = ReqAddr;
                    rem_d     = (ReqLen == '0) ? ((ADDR_W+1)'(1) << ADDR_W) : {1'b0, ReqLen};
                    err_cnt_d = 8'd0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - (ADDR_W+1)'(1);
                    if (rem_q == (ADDR_W+1)'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge RdClock or negedge RdResetN) begin
        if (!RdResetN) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_data_q[0]  <= '0;
            fifo_data_q[1]  <= '0;
            fifo_last_q     <= '0;
            fifo_err_q      <= '0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= '0;
            done_q          <= 1'b0;
            err_cnt_q       <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            fifo_data_q[0]  <= fifo_data_d[0];
            fifo_data_q[1]  <= fifo_data_d[1];
            fifo_last_q     <= fifo_last_d;
            fifo_err_q      <= fifo_err_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            done_q          <= done_d;
            err_cnt_q       <= err_cnt_d;
        end
    end

    assign ReqReady  = (state_q == IDLE);
    assign Busy      = (state_q != IDLE);
    assign RdEn      = issue;
    assign RdAddress = addr_q;
    assign OutValid  = (count_q != 2'd0);
    assign OutData   = fifo_data_q[rd_ptr_q];
    assign OutLast   = head_last;
    assign OutErr    = head_err;
    assign Done      = done_q;
    assign ErrCount  = err_cnt_q;

endmodule

// File: tb/tb_dp_1024x32_reader.sv
// Testbench for dp_1024x32_reader: EBR behavioural memory plus a word-level
// reference model (expected word/address queues) checked every cycle.
module tb_dp_1024x32_reader;

    logic        RdClock = 1'b0;
    logic        RdResetN;
    logic        ReqValid;
    logic        ReqReady;
    logic [9:0]  ReqAddr;
    logic [9:0]  ReqLen;
    logic        RdEn;
    logic [9:0]  RdAddress;
    logic [31:0] Q;
    logic [3:0]  EDO;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] OutData;
    logic        OutLast;
    logic        OutErr;
    logic        Busy;
    logic        Done;
    logic [7:0]  ErrCount;

    always #5 RdClock = ~RdClock;

    dp_1024x32_reader dut (
        .RdClock(RdClock), .RdResetN(RdResetN),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqAddr(ReqAddr), .ReqLen(ReqLen),
        .RdEn(RdEn), .RdAddress(RdAddress), .Q(Q), .EDO(EDO),
        .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
        .OutLast(OutLast), .OutErr(OutErr),
        .Busy(Busy), .Done(Done), .ErrCount(ErrCount)
    );

    // EBR model: registered read, data appears the cycle after RdEn is sampled.
    logic [31:0] mem_data [1024];
    logic [3:0]  mem_edo  [1024];
    always @(posedge RdClock) begin
        if (RdEn) begin
            Q   <= mem_data[RdAddress];
            EDO <= mem_edo[RdAddress];
        end
    end

    typedef struct {
        logic [31:0] d;
        logic        last;
        logic        err;
    } word_t;

    word_t       exp_q[$];
    logic [9:0]  addr_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    bit          busy_m, done_exp, prev_stall, done_seen;
    logic [31:0] prev_d;
    logic        prev_l, prev_e;
    int          errcnt_m, outstanding, cyc_n;
    int          first_rd, first_val, done_cyc;

    function automatic logic [3:0] par4(logic [31:0] d);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) p[i] = ^d[8*i +: 8];
        return p;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ready_for(int mode, int k);
        if (mode == 1) return 1'($urandom_range(0, 2) != 0);
        if (mode == 2) return ((k % 4) == 0) || ((k % 4) == 3);
        return 1'b1;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        addr_q.delete();
        busy_m = 0; done_exp = 0; prev_stall = 0;
        errcnt_m = 0; outstanding = 0;
    endtask

    // One clock cycle: inputs already applied after the falling edge.
    task automatic run_cycle();
        bit    hs, acc;
        word_t w;
        int    n;
        #1;
        w.d = '0; w.last = 1'b0; w.err = 1'b0;
        check("done", 32'(Done), 32'(done_exp));
        check("busy", 32'(Busy), 32'(busy_m));
        check("req_ready", 32'(ReqReady), 32'(!busy_m));
        check("err_count", 32'(ErrCount), 32'(errcnt_m));
        if (OutValid && exp_q.size() == 0) check("stale_valid", 32'(OutValid), 32'd0);
        if (prev_stall) begin
            check("hold_valid", 32'(OutValid), 32'd1);
            check("hold_data", OutData, prev_d);
            check("hold_last", 32'(OutLast), 32'(prev_l));
            check("hold_err", 32'(OutErr), 32'(prev_e));
        end
        hs = OutValid && OutReady;
        if (RdEn) begin
            if (addr_q.size() == 0) check("extra_rden", 32'(RdEn), 32'd0);
            else check("rd_addr", 32'(RdAddress), 32'(addr_q.pop_front()));
            check("credit", 32'((outstanding - int'(hs)) < 2), 32'd1);
            if (first_rd < 0) first_rd = cyc_n;
        end
        check("buffered_max", 32'(outstanding <= 2), 32'd1);
        if (OutValid && first_val < 0) first_val = cyc_n;
        if (Done === 1'b1) begin
            done_seen = 1;
            done_cyc  = cyc_n;
        end
        if (hs && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check("out_data", OutData, w.d);
            check("out_last", 32'(OutLast), 32'(w.last));
            check("out_err", 32'(OutErr), 32'(w.err));
            $display("word data=%08h last=%0b err=%0b cycle=%0d", OutData, OutLast, OutErr, cyc_n);
        end
        acc = ReqValid && ReqReady;
        done_exp = hs && w.last;
        if (acc) begin
            busy_m = 1; errcnt_m = 0;
            n = (ReqLen == 10'd0) ? 1024 : int'(ReqLen);
            for (int i = 0; i < n; i++) begin
                word_t     e;
                logic [9:0] a;
                a      = 10'((int'(ReqAddr) + i) % 1024);
                e.d    = mem_data[a];
                e.last = (i == n - 1);
                e.err  = |(mem_edo[a] ^ par4(mem_data[a]));
                exp_q.push_back(e);
                addr_q.push_back(a);
            end
        end else if (hs && w.err && errcnt_m < 255) begin
            errcnt_m++;
        end
        if (hs && w.last) busy_m = 0;
        outstanding += int'(RdEn) - int'(hs);
        prev_stall = OutValid && !OutReady;
        prev_d = OutData; prev_l = OutLast; prev_e = OutErr;
        @(negedge RdClock);
        cyc_n++;
    endtask

    task automatic burst(logic [9:0] a, logic [9:0] l, int mode, int limit);
        int t_acc, n, k;
        n = (l == 10'd0) ? 1024 : int'(l);
        first_rd = -1; first_val = -1; done_cyc = -1; done_seen = 0;
        ReqAddr = a; ReqLen = l; ReqValid = 1'b1; OutReady = 1'b1;
        t_acc = cyc_n;
        run_cycle();
        ReqValid = 1'b0;
        k = 1;
        while (!done_seen && k < limit) begin
            OutReady = ready_for(mode, k);
            run_cycle();
            k++;
        end
        check("burst_timeout", 32'(done_seen), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        if (mode == 0) begin
            check("lat_rden", 32'(first_rd), 32'(t_acc + 1));
            check("lat_valid", 32'(first_val), 32'(t_acc + 3));
            check("lat_done", 32'(done_cyc), 32'(t_acc + n + 3));
        end
        $display("burst addr=%0d len=%0d mode=%0d accepted=%0d done=%0d", a, n, mode, t_acc, done_cyc);
    endtask

    initial begin
        logic [9:0] ra;
        logic [9:0] rl;
        for (int i = 0; i < 1024; i++) begin
            mem_data[i] = $urandom;
            mem_edo[i]  = par4(mem_data[i]);
        end
        RdResetN = 1'b0; ReqValid = 1'b0; ReqAddr = '0; ReqLen = '0; OutReady = 1'b0;
        model_reset();
        cyc_n = 0; first_rd = -1; first_val = -1; done_cyc = -1; done_seen = 0;
        @(negedge RdClock);
        @(negedge RdClock);
        #1;
        check("rst_req_ready", 32'(ReqReady), 32'd1);
        check("rst_rden", 32'(RdEn), 32'd0);
        check("rst_out_valid", 32'(OutValid), 32'd0);
        check("rst_out_data", OutData, 32'd0);
        check("rst_err_count", 32'(ErrCount), 32'd0);
        @(negedge RdClock);
        RdResetN = 1'b1;

        // Single word at address 5
        mem_data[5] = 32'h12345678;
        mem_edo[5]  = par4(32'h12345678);
        burst(10'd5, 10'd1, 0, 20);

        // Address wrap 1022 -> 1
        burst(10'd1022, 10'd4, 0, 20);

        // Back-pressure pattern 1,0,0,1
        burst(10'd100, 10'd8, 2, 80);

        // Parity error on the middle word of three
        mem_edo[201] = mem_edo[201] ^ 4'b0010;
        burst(10'd200, 10'd3, 0, 20);
        check("errcnt_after_burst", 32'(ErrCount), 32'd1);
        mem_edo[201] = par4(mem_data[201]);
        burst(10'd300, 10'd2, 0, 20);
        check("errcnt_cleared", 32'(ErrCount), 32'd0);

        // Randomised bursts with random stalls and sprinkled parity faults
        for (int r = 0; r < 10; r++) begin
            for (int f = 0; f < 4; f++) begin
                ra = 10'($urandom_range(0, 1023));
                mem_edo[ra] = mem_edo[ra] ^ 4'(1 << $urandom_range(0, 3));
            end
            ra = 10'($urandom_range(0, 1023));
            rl = 10'($urandom_range(1, 24));
            burst(ra, rl, 1, 40 * int'(rl) + 50);
        end

        // ErrCount saturation: 300 consecutive bad words
        for (int i = 400; i < 700; i++) mem_edo[i] = ~par4(mem_data[i]);
        burst(10'd400, 10'd300, 0, 400);
        check("errcnt_saturated", 32'(ErrCount), 32'd255);
        for (int i = 0; i < 1024; i++) mem_edo[i] = par4(mem_data[i]);

        // Full 1024-word burst
        burst(10'd0, 10'd0, 0, 1100);

        // Asynchronous reset during an 8-word burst
        ReqAddr = 10'd50; ReqLen = 10'd8; ReqValid = 1'b1; OutReady = 1'b1;
        run_cycle();
        ReqValid = 1'b0;
        for (int i = 0; i < 3; i++) run_cycle();
        #2;
        RdResetN = 1'b0;
        #1;
        check("arst_req_ready", 32'(ReqReady), 32'd1);
        check("arst_rden", 32'(RdEn), 32'd0);
        check("arst_rd_address", 32'(RdAddress), 32'd0);
        check("arst_out_valid", 32'(OutValid), 32'd0);
        check("arst_out_data", OutData, 32'd0);
        check("arst_out_last", 32'(OutLast), 32'd0);
        check("arst_out_err", 32'(OutErr), 32'd0);
        check("arst_busy", 32'(Busy), 32'd0);
        check("arst_done", 32'(Done), 32'd0);
        check("arst_err_count", 32'(ErrCount), 32'd0);
        model_reset();
        @(negedge RdClock);
        @(negedge RdClock);
        RdResetN = 1'b1;
        for (int i = 0; i < 4; i++) run_cycle();
        burst(10'd60, 10'd2, 0, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
